// File: rtl/player_mover.sv
// rtl/player_mover.sv - two-player step engine: direction filtering, wrapped moves, grid strobes, win/crash check
module player_mover #(
  parameter int unsigned P1_START_X = 16,
  parameter int unsigned P1_START_Y = 32,
  parameter int unsigned P2_START_X = 47,
  parameter int unsigned P2_START_Y = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic [1:0]  dir_one,
  input  logic [1:0]  dir_two,
  input  logic        isWinOne,
  input  logic        isWinTwo,
  input  logic        isCrash,
  output logic [31:0] play_x,
  output logic [31:0] play_y,
  output logic        is_play_one,
  output logic        is_play_two,
  output logic        game_over,
  output logic [1:0]  result,
  output logic [15:0] step_count
);

  localparam logic [5:0] LP_P1_X = 6'(P1_START_X);
  localparam logic [5:0] LP_P1_Y = 6'(P1_START_Y);
  localparam logic [5:0] LP_P2_X = 6'(P2_START_X);
  localparam logic [5:0] LP_P2_Y = 6'(P2_START_Y);
  localparam logic [1:0] LP_DIR1_LOAD = 2'b01;
  localparam logic [1:0] LP_DIR2_LOAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_P1,
    S_P2,
    S_SETTLE,
    S_CHECK,
    S_OVER
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_x1;
  logic [5:0]  r_y1;
  logic [5:0]  r_x2;
  logic [5:0]  r_y2;
  logic [1:0]  r_dir1;
  logic [1:0]  r_dir2;
  logic [1:0]  r_result;
  logic [15:0] r_step_count;

  logic [1:0]  w_dir1_acc;
  logic [1:0]  w_dir2_acc;
  logic [11:0] w_next1;
  logic [11:0] w_next2;
  logic        w_load;
  logic        w_accept_tick;
  logic        w_any_flag;
  logic [1:0]  w_result_new;

  // Six-bit arithmetic gives the modulo-64 wrap for free.
  function automatic logic [11:0] f_next_pos(
    input logic [5:0] x,
    input logic [5:0] y,
    input logic [1:0] d
  );
    logic [5:0] nx;
    logic [5:0] ny;
    nx = x;
    ny = y;
    case (d)
      2'b00:   ny = y - 6'd1;
      2'b01:   nx = x + 6'd1;
      2'b10:   ny = y + 6'd1;
      default: nx = x - 6'd1;
    endcase
    return {nx, ny};
  endfunction

  // A request pointing straight back is a reversal and is dropped.
  assign w_dir1_acc = (dir_one == (r_dir1 ^ 2'b10)) ? r_dir1 : dir_one;
  assign w_dir2_acc = (dir_two == (r_dir2 ^ 2'b10)) ? r_dir2 : dir_two;

  assign w_next1 = f_next_pos(r_x1, r_y1, w_dir1_acc);
  assign w_next2 = f_next_pos(r_x2, r_y2, w_dir2_acc);

  assign w_load        = start && ((r_state == S_IDLE) || (r_state == S_OVER));
  assign w_accept_tick = tick && (r_state == S_RUN);
  assign w_any_flag    = isCrash || isWinOne || isWinTwo;

  always_comb begin
    w_result_new = 2'b00;
    if (isCrash || (isWinOne && isWinTwo)) begin
      w_result_new = 2'b11;
    end else if (isWinOne) begin
      w_result_new = 2'b01;
    end else if (isWinTwo) begin
      w_result_new = 2'b10;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_RUN;
      S_RUN:    if (tick) w_state_next = S_P1;
      S_P1:     w_state_next = S_P2;
      S_P2:     w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_CHECK;
      S_CHECK:  w_state_next = w_any_flag ? S_OVER : S_RUN;
      S_OVER:   if (start) w_state_next = S_RUN;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_x1         <= LP_P1_X;
      r_y1         <= LP_P1_Y;
      r_x2         <= LP_P2_X;
      r_y2         <= LP_P2_Y;
      r_dir1       <= LP_DIR1_LOAD;
      r_dir2       <= LP_DIR2_LOAD;
      r_result     <= 2'b00;
      r_step_count <= 16'd0;
    end else begin
      r_state <= w_state_next;

      if (w_load) begin
        r_x1         <= LP_P1_X;
        r_y1         <= LP_P1_Y;
        r_x2         <= LP_P2_X;
        r_y2         <= LP_P2_Y;
        r_dir1       <= LP_DIR1_LOAD;
        r_dir2       <= LP_DIR2_LOAD;
        r_result     <= 2'b00;
        r_step_count <= 16'd0;
      end

      if (w_accept_tick) begin
        r_dir1 <= w_dir1_acc;
        r_dir2 <= w_dir2_acc;
        {r_x1, r_y1} <= w_next1;
        {r_x2, r_y2} <= w_next2;
      end

      if (r_state == S_CHECK) begin
        if (r_step_count != 16'hFFFF) begin
          r_step_count <= r_step_count + 16'd1;
        end
        if (w_any_flag) begin
          r_result <= w_result_new;
        end
      end
    end
  end

  // The grid bus is shared, so only the strobed player's position is ever presented.
  always_comb begin
    play_x      = 32'd0;
    play_y      = 32'd0;
    is_play_one = 1'b0;
    is_play_two = 1'b0;
    case (r_state)
      S_P1: begin
        play_x      = {26'd0, r_x1};
        play_y      = {26'd0, r_y1};
        is_play_one = 1'b1;
      end
      S_P2: begin
        play_x      = {26'd0, r_x2};
        play_y      = {26'd0, r_y2};
        is_play_two = 1'b1;
      end
      default: begin
        play_x      = 32'd0;
        play_y      = 32'd0;
      end
    endcase
  end

  assign game_over  = (r_state == S_OVER);
  assign result     = r_result;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - directed scoreboard bench for player_mover
module tb_player_mover;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        tick;
  logic [1:0]  dir_one;
  logic [1:0]  dir_two;
  logic        isWinOne;
  logic        isWinTwo;
  logic        isCrash;
  logic [31:0] play_x;
  logic [31:0] play_y;
  logic        is_play_one;
  logic        is_play_two;
  logic        game_over;
  logic [1:0]  result;
  logic [15:0] step_count;

  player_mover dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .tick        (tick),
    .dir_one     (dir_one),
    .dir_two     (dir_two),
    .isWinOne    (isWinOne),
    .isWinTwo    (isWinTwo),
    .isCrash     (isCrash),
    .play_x      (play_x),
    .play_y      (play_y),
    .is_play_one (is_play_one),
    .is_play_two (is_play_two),
    .game_over   (game_over),
    .result      (result),
    .step_count  (step_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [65:0] sb[$];

  int          m_x1, m_y1, m_x2, m_y2;
  logic [1:0]  m_d1, m_d2;
  int          m_steps;
  logic [1:0]  m_result;
  logic        m_over;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] accept(input logic [1:0] cur, input logic [1:0] req);
    logic [1:0] rev;
    rev = {~cur[1], cur[0]};
    return (req == rev) ? cur : req;
  endfunction

  function automatic int wrap64(input int v);
    return (v + 64) % 64;
  endfunction

  task automatic move(inout int x, inout int y, input logic [1:0] d);
    if (d == 2'b00) y = wrap64(y - 1);
    if (d == 2'b10) y = wrap64(y + 1);
    if (d == 2'b01) x = wrap64(x + 1);
    if (d == 2'b11) x = wrap64(x - 1);
  endtask

  function automatic logic [65:0] strobe_word(input bit one, input int x, input int y);
    logic [31:0] xx;
    logic [31:0] yy;
    xx = x;
    yy = y;
    return {one, ~one, xx, yy};
  endfunction

  task automatic load_model();
    m_x1 = 16; m_y1 = 32; m_x2 = 47; m_y2 = 32;
    m_d1 = 2'b01; m_d2 = 2'b11;
    m_steps = 0; m_result = 2'b00; m_over = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_sb_drain"}, sb.size(), 0);
    chk({tag, "_step_count"}, step_count, m_steps);
    chk({tag, "_game_over"}, game_over, m_over);
    chk({tag, "_result"}, result, m_result);
  endtask

  always @(negedge clock) begin
    if (is_play_one || is_play_two) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {is_play_one, is_play_two, play_x, play_y}, 66'd0);
      end else begin
        chk("strobe", {is_play_one, is_play_two, play_x, play_y}, sb.pop_front());
      end
    end else begin
      chk("idle_bus_zero", {2'b00, play_x, play_y}, 66'd0);
    end
  end

  task automatic do_start(input string tag);
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    load_model();
    check_status(tag);
  endtask

  task automatic do_step(input string tag, input logic [1:0] d1, input logic [1:0] d2,
                         input logic crash, input logic w1, input logic w2, input bit extra_tick);
    @(posedge clock); #1;
    dir_one = d1; dir_two = d2;
    isCrash = crash; isWinOne = w1; isWinTwo = w2;
    tick = 1'b1;
    m_d1 = accept(m_d1, d1);
    m_d2 = accept(m_d2, d2);
    move(m_x1, m_y1, m_d1);
    move(m_x2, m_y2, m_d2);
    sb.push_back(strobe_word(1'b1, m_x1, m_y1));
    sb.push_back(strobe_word(1'b0, m_x2, m_y2));
    @(posedge clock); #1;
    tick = 1'b0;
    @(posedge clock); #1;
    if (extra_tick) tick = 1'b1;
    @(posedge clock); #1;
    tick = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    isCrash = 1'b0; isWinOne = 1'b0; isWinTwo = 1'b0;
    if (m_steps < 65535) m_steps++;
    if (crash || (w1 && w2)) m_result = 2'b11;
    else if (w1) m_result = 2'b01;
    else if (w2) m_result = 2'b10;
    if (crash || w1 || w2) m_over = 1'b1;
    check_status(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      tick = 1'b1;
      @(posedge clock); #1;
      tick = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check_status(tag);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    dir_one = 2'b01; dir_two = 2'b11;
    isWinOne = 1'b0; isWinTwo = 1'b0; isCrash = 1'b0;
    load_model();
    repeat (3) @(posedge clock);
    #1;
    check_status("reset");
    reset = 1'b0;

    idle_ticks("idle_tick_ignored", 1);

    do_start("start");
    do_step("first_step", 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    do_step("reversal", 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    do_step("tick_in_p2", 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) @(posedge clock);
    #1;
    check_status("after_p2_tick");

    for (int i = 0; i < 46; i++) begin
      do_step("wrap_walk", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    do_step("crash_and_win", 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_ticks("over_ticks", 3);

    do_start("restart");
    do_step("restart_step", 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    do_step("win_one", 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    do_start("restart2");
    do_step("win_two", 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    do_start("restart3");
    do_step("both_win", 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    do_start("restart4");
    do_step("pre_reset_step", 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    @(posedge clock); #1;
    tick = 1'b1;
    m_d1 = accept(m_d1, dir_one);
    move(m_x1, m_y1, m_d1);
    sb.push_back(strobe_word(1'b1, m_x1, m_y1));
    @(posedge clock); #1;
    tick = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    load_model();
    check_status("reset_in_p1");
    idle_ticks("post_reset_idle", 2);

    @(posedge clock); #1;
    reset = 1'b1; start = 1'b1; tick = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0; tick = 1'b0;
    check_status("reset_beats_start");
    idle_ticks("still_idle", 1);

    do_start("final_start");
    do_step("final_step", 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 SHALL have parameter P1_START_X, default 16, player one start column.
REQ-002 SHALL have parameter P1_START_Y, default 32, player one start row.
REQ-003 SHALL have parameter P2_START_X, default 47, player two start column.
REQ-004 SHALL have parameter P2_START_Y, default 32, player two start row.
REQ-005 SHALL have port clock  in  1  single system clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1  level; begins a game from IDLE or restarts one from OVER.
REQ-008 SHALL have port tick  in  1  one-cycle game-step strobe.
REQ-009 SHALL have port dir_one  in  2  player one requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
REQ-010 SHALL have port dir_two  in  2  player two requested direction, same encoding.
REQ-011 SHALL have port isWinOne  in  1  grid flag: player one won.
REQ-012 SHALL have port isWinTwo  in  1  grid flag: player two won.
REQ-013 SHALL have port isCrash  in  1  grid flag: head-on collision.
REQ-014 SHALL have port play_x  out  32  column presented to the grid; bits [31:6] always 0.
REQ-015 SHALL have port play_y  out  32  row presented to the grid; bits [31:6] always 0.
REQ-016 SHALL have port is_play_one  out  1  strobe: play_x/play_y carry player one's position.
REQ-017 SHALL have port is_play_two  out  1  strobe: play_x/play_y carry player two's position.
REQ-018 SHALL have port game_over  out  1  high while in OVER.
REQ-019 SHALL have port result  out  2  00 none, 01 player one won, 10 player two won, 11 draw.
REQ-020 SHALL have port step_count  out  16  completed game steps since the last load.

Function
REQ-021 SHALL implement the FSM states IDLE, RUN, P1, P2, SETTLE, CHECK and OVER.
REQ-022 SHALL transition from IDLE to RUN when start=1, loading the start positions, dir1=01, dir2=11, step_count=0 and result=00.
REQ-023 SHALL, in RUN with tick=1, register the accepted directions, compute both next positions and transition to P1; in RUN with tick=0, SHALL remain in RUN.
REQ-024 SHALL treat a requested direction equal to the current direction XOR 2'b10 (a reversal) as rejected and keep the current direction.
REQ-025 SHALL compute the next position with 6-bit modulo-64 arithmetic (63+1 wraps to 0, 0-1 wraps to 63).
REQ-026 SHALL, in P1, drive player one's new position with is_play_one=1 for exactly one cycle, then transition to P2.
REQ-027 SHALL, in P2, drive player two's new position with is_play_two=1 for exactly one cycle, then transition to SETTLE.
REQ-028 SHALL never assert is_play_one and is_play_two in the same cycle.
REQ-029 SHALL drive play_x and play_y as 0 whenever neither strobe is high.
REQ-030 SHALL spend exactly one cycle in SETTLE, then transition to CHECK.
REQ-031 SHALL, in CHECK, sample the grid flags, increment step_count (saturating at 16'hFFFF) and go to OVER if any flag is set, otherwise return to RUN.
REQ-032 SHALL set result in CHECK with this precedence: isCrash=1 or both win flags set gives 11; else isWinOne gives 01; else isWinTwo gives 10.
REQ-033 SHALL ignore tick pulses outside RUN; they are not queued.
REQ-034 SHALL ignore start outside IDLE and OVER.
REQ-035 SHALL hold positions, result and step_count in OVER, and SHALL reload and enter RUN when start=1.
REQ-036 SHALL place a P1 strobe 1 cycle after the accepting tick and a P2 strobe 2 cycles after it; the next tick SHALL be accepted no earlier than 5 cycles after the previous one.

Reset
REQ-037 SHALL, on reset=1 at a clock edge, enter IDLE from any state, including mid-step.
REQ-038 SHALL reset every output to 0 and both internal directions to their load values.
REQ-039 SHALL give reset priority over start and tick in the same cycle.

Verification
REQ-040 SHALL cover: reset, then start, then one tick with dir_one=01 and dir_two=11 -> is_play_one at (17,32) one cycle later, then is_play_two at (46,32), game_over=0, step_count=1.
REQ-041 SHALL cover: player one at x=63 moving right with tick -> play_x=0; player two at y=0 moving up -> play_y=63.
REQ-042 SHALL cover: player one moving right with dir_one=11 requested -> direction stays 01 and x increments.
REQ-043 SHALL cover: isCrash=1 and isWinOne=1 held during CHECK -> game_over=1, result=11, and later ticks produce no strobes.
REQ-044 SHALL cover: a tick pulsed during P2 -> no extra step, step_count increments by exactly 1.
REQ-045 SHALL cover: reset asserted during the P1 cycle -> IDLE next cycle, all outputs 0; start in OVER -> positions reloaded, result=00.
